// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared encodings for the byte-serial memory controller
package mem_ctrl_pkg;

    localparam int VALID_BIT_W = 2;

    localparam logic [VALID_BIT_W-1:0] SIZE_NONE = 2'b00;
    localparam logic [VALID_BIT_W-1:0] SIZE_BYTE = 2'b01;
    localparam logic [VALID_BIT_W-1:0] SIZE_HALF = 2'b10;
    localparam logic [VALID_BIT_W-1:0] SIZE_WORD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_LAST  = 2'd2,
        ST_ACK   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OP_IFETCH = 2'd0,
        OP_DREAD  = 2'd1,
        OP_DWRITE = 2'd2
    } op_e;

    // Index of the final byte of an access (N-1) for a size code.
    function automatic logic [1:0] last_index(input logic [VALID_BIT_W-1:0] size);
        case (size)
            SIZE_HALF: return 2'd1;
            SIZE_WORD: return 2'd3;
            default:   return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_lane.sv
// rtl/mem_ctrl_lane.sv - byte lane extract for writes and byte lane insert for read assembly
module mem_ctrl_lane (
    input  logic [31:0] wdata,
    input  logic [1:0]  wr_lane,
    output logic [7:0]  wr_byte,
    input  logic [31:0] asm_in,
    input  logic [1:0]  rd_lane,
    input  logic [7:0]  rd_byte,
    output logic [31:0] asm_out
);

    assign wr_byte = wdata[{wr_lane, 3'b000} +: 8];

    always_comb begin
        asm_out = asm_in;
        asm_out[{rd_lane, 3'b000} +: 8] = rd_byte;
    end

endmodule

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - serialises data reads/writes and instruction fetches onto a byte-wide RAM
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   re_m,
    input  logic [VALID_BIT_W-1:0] rvalid_bit,
    input  logic [ADDR_W-1:0]      raddr_m,
    output logic [31:0]            rdata_m,
    input  logic                   we_m,
    input  logic [VALID_BIT_W-1:0] wvalid_bit,
    input  logic [ADDR_W-1:0]      waddr_m,
    input  logic [31:0]            wdata_m,
    input  logic                   if_req,
    input  logic [ADDR_W-1:0]      if_addr,
    output logic [31:0]            if_data,
    output logic                   if_done,
    output logic                   stall_req,
    output logic [ADDR_W-1:0]      mem_a,
    output logic [7:0]             mem_dout,
    input  logic [7:0]             mem_din,
    output logic                   mem_wr
);

    state_e                 state;
    state_e                 state_next;
    op_e                    op;
    logic [ADDR_W-1:0]      base;
    logic [1:0]             last_idx;
    logic [31:0]            wdata_q;
    logic [1:0]             cnt;
    logic [31:0]            asm_q;
    logic [31:0]            asm_next;
    logic [7:0]             wbyte;
    logic [1:0]             cap_lane;

    logic                   rd_req;
    logic                   wr_req;
    logic                   data_req;
    logic                   accept;
    op_e                    acc_op;
    logic [ADDR_W-1:0]      acc_addr;
    logic [VALID_BIT_W-1:0] acc_size;
    logic                   issuing;

    assign wr_req   = we_m && (wvalid_bit != SIZE_NONE);
    assign rd_req   = re_m && (rvalid_bit != SIZE_NONE);
    assign data_req = wr_req || rd_req;

    // Arbitration only happens in IDLE; writes beat reads, data beats fetch.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        acc_op     = OP_IFETCH;
        acc_addr   = if_addr;
        acc_size   = SIZE_WORD;
        case (state)
            ST_IDLE: begin
                if (wr_req) begin
                    accept   = 1'b1;
                    acc_op   = OP_DWRITE;
                    acc_addr = waddr_m;
                    acc_size = wvalid_bit;
                end else if (rd_req) begin
                    accept   = 1'b1;
                    acc_op   = OP_DREAD;
                    acc_addr = raddr_m;
                    acc_size = rvalid_bit;
                end else if (if_req) begin
                    accept   = 1'b1;
                end
                if (accept) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cnt == last_idx) begin
                    state_next = (op == OP_DWRITE) ? ST_ACK : ST_LAST;
                end
            end
            ST_LAST: state_next = ST_ACK;
            ST_ACK:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // RAM returns data one cycle late, so ISSUE byte k lands in lane k-1; LAST takes the tail.
    assign cap_lane = (state == ST_LAST) ? last_idx : (cnt - 2'd1);

    mem_ctrl_lane u_lane (
        .wdata   (wdata_q),
        .wr_lane (cnt),
        .wr_byte (wbyte),
        .asm_in  (asm_q),
        .rd_lane (cap_lane),
        .rd_byte (mem_din),
        .asm_out (asm_next)
    );

    assign issuing  = (state == ST_ISSUE);
    assign mem_a    = issuing ? (base + ADDR_W'(cnt)) : '0;
    assign mem_wr   = issuing && (op == OP_DWRITE);
    assign mem_dout = mem_wr ? wbyte : 8'h00;

    assign stall_req = !rst && data_req && !((state == ST_ACK) && (op != OP_IFETCH));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            op       <= OP_IFETCH;
            base     <= '0;
            last_idx <= '0;
            wdata_q  <= '0;
            cnt      <= '0;
            asm_q    <= '0;
            rdata_m  <= '0;
            if_data  <= '0;
            if_done  <= 1'b0;
        end else begin
            state   <= state_next;
            if_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op       <= acc_op;
                        base     <= acc_addr;
                        last_idx <= last_index(acc_size);
                        wdata_q  <= wdata_m;
                        cnt      <= '0;
                        asm_q    <= '0;
                    end
                end
                ST_ISSUE: begin
                    cnt <= cnt + 2'd1;
                    if ((op != OP_DWRITE) && (cnt != 2'd0)) begin
                        asm_q <= asm_next;
                    end
                end
                ST_LAST: begin
                    // Results are loaded here so they are already visible during ACK.
                    asm_q <= asm_next;
                    if (op == OP_DREAD) begin
                        rdata_m <= asm_next;
                    end else begin
                        if_data <= asm_next;
                        if_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - randomized scoreboard bench for mem_ctrl against a byte-array model
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        re_m, we_m, if_req, if_done, stall_req, mem_wr;
    logic [1:0]  rvalid_bit, wvalid_bit;
    logic [31:0] raddr_m, waddr_m, wdata_m, if_addr, rdata_m, if_data, mem_a;
    logic [7:0]  mem_dout, mem_din;

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .re_m       (re_m),
        .rvalid_bit (rvalid_bit),
        .raddr_m    (raddr_m),
        .rdata_m    (rdata_m),
        .we_m       (we_m),
        .wvalid_bit (wvalid_bit),
        .waddr_m    (waddr_m),
        .wdata_m    (wdata_m),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_data    (if_data),
        .if_done    (if_done),
        .stall_req  (stall_req),
        .mem_a      (mem_a),
        .mem_dout   (mem_dout),
        .mem_din    (mem_din),
        .mem_wr     (mem_wr)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // External byte RAM: the low 12 address bits index it; test windows never alias.
    logic [7:0]  dev_ram [4096];
    logic [7:0]  ref_ram [4096];
    logic        ram_init = 1'b1;
    logic        poke = 1'b0;
    logic [11:0] poke_a = '0;
    logic [7:0]  poke_d = '0;
    int          wr_cnt = 0;

    function automatic logic [7:0] init_byte(input logic [11:0] a);
        return a[7:0] ^ {a[11:8], a[3:0]} ^ 8'h5A;
    endfunction

    always @(posedge clk) begin
        mem_din <= dev_ram[mem_a[11:0]];
        if (ram_init) begin
            for (int i = 0; i < 4096; i++) dev_ram[i] <= init_byte(12'(i));
        end else if (poke) begin
            dev_ram[poke_a] <= poke_d;
        end else if (mem_wr) begin
            dev_ram[mem_a[11:0]] <= mem_dout;
            wr_cnt <= wr_cnt + 1;
        end
    end

    function automatic logic [31:0] ref_read(input logic [31:0] a, input int n);
        logic [31:0] v;
        logic [31:0] ak;
        v = '0;
        for (int k = 0; k < n; k++) begin
            ak = a + 32'(k);
            v[8*k +: 8] = ref_ram[ak[11:0]];
        end
        return v;
    endfunction

    task automatic ref_write(input logic [31:0] a, input int n, input logic [31:0] d);
        logic [31:0] ak;
        for (int k = 0; k < n; k++) begin
            ak = a + 32'(k);
            ref_ram[ak[11:0]] = d[8*k +: 8];
        end
    endtask

    task automatic preset(input logic [31:0] a, input logic [7:0] d);
        ref_ram[a[11:0]] = d;
        poke_a = a[11:0];
        poke_d = d;
        poke   = 1'b1;
        @(posedge clk);
        #1 poke = 1'b0;
    endtask

    typedef struct {
        bit          is_read;
        logic [31:0] data;
        int          lat;
        int          nbytes;
        int          start;
        int          wr_start;
    } exp_t;

    exp_t        dq[$];
    exp_t        fq[$];
    exp_t        me, mf;
    logic [31:0] last_rd = '0;
    logic        prev_done = 1'b0;
    int          data_done_cyc = 0;
    int          fetch_done_cyc = 0;
    logic        data_present;

    assign data_present = (we_m && wvalid_bit != 2'b00) || (re_m && rvalid_bit != 2'b00);

    // Monitor: a data access completes in the cycle stall_req drops while a request is up.
    always @(negedge clk) begin
        if (!rst) begin
            if (data_present && !stall_req) begin
                data_done_cyc = cyc;
                if (dq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_data_ack: no access outstanding (cycle %0d)", cyc);
                end else begin
                    me = dq.pop_front();
                    chk("data_latency", 32'(cyc - me.start), 32'(me.lat));
                    if (me.is_read) begin
                        chk("rdata_m", rdata_m, me.data);
                        last_rd = me.data;
                    end else begin
                        chk("rdata_hold", rdata_m, last_rd);
                        chk("write_strobes", 32'(wr_cnt - me.wr_start), 32'(me.nbytes));
                    end
                end
            end
            if (if_done) begin
                fetch_done_cyc = cyc;
                chk("if_done_pulse", {31'b0, prev_done}, 32'd0);
                if (fq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_if_done: no fetch outstanding (cycle %0d)", cyc);
                end else begin
                    mf = fq.pop_front();
                    chk("if_data", if_data, mf.data);
                    if (mf.lat >= 0) chk("fetch_latency", 32'(cyc - mf.start), 32'(mf.lat));
                end
            end
        end
        prev_done = if_done;
    end

    task automatic wait_data();
        bit seen;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (!stall_req) seen = 1;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL data_timeout: stall_req never dropped (cycle %0d)", cyc);
        end
    endtask

    task automatic wait_fetch();
        bit seen;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (if_done) seen = 1;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL fetch_timeout: if_done never seen (cycle %0d)", cyc);
        end
    endtask

    task automatic data_op(input bit wr, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] d, input bit with_fetch, input logic [31:0] fa);
        exp_t e, f;
        int   n;
        n = (sz == 2'b01) ? 1 : (sz == 2'b10) ? 2 : 4;
        @(posedge clk);
        #1;
        e.is_read  = !wr;
        e.nbytes   = wr ? n : 0;
        e.lat      = wr ? n + 1 : n + 2;
        e.start    = cyc;
        e.wr_start = wr_cnt;
        if (wr) begin
            ref_write(a, n, d);
            e.data = '0;
        end else begin
            e.data = ref_read(a, n);
        end
        dq.push_back(e);
        if (wr) begin
            we_m = 1'b1; wvalid_bit = sz; waddr_m = a; wdata_m = d;
        end else begin
            re_m = 1'b1; rvalid_bit = sz; raddr_m = a;
        end
        if (with_fetch) begin
            f.is_read = 1; f.data = ref_read(fa, 4); f.lat = -1; f.nbytes = 0;
            f.start = cyc; f.wr_start = 0;
            fq.push_back(f);
            if_req = 1'b1; if_addr = fa;
        end
        wait_data();
        @(posedge clk);
        #1;
        we_m = 1'b0; re_m = 1'b0; wvalid_bit = 2'b00; rvalid_bit = 2'b00;
        if (with_fetch) begin
            wait_fetch();
            @(posedge clk);
            #1 if_req = 1'b0;
            chk("fetch_after_data", {31'b0, fetch_done_cyc > data_done_cyc}, 32'd1);
        end
    endtask

    task automatic fetch_op(input logic [31:0] fa);
        exp_t f;
        @(posedge clk);
        #1;
        f.is_read = 1; f.data = ref_read(fa, 4); f.lat = 6; f.nbytes = 0;
        f.start = cyc; f.wr_start = 0;
        fq.push_back(f);
        if_req = 1'b1; if_addr = fa;
        wait_fetch();
        @(posedge clk);
        #1 if_req = 1'b0;
    endtask

    function automatic logic [31:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        return 32'h0000_0100 + 32'($urandom_range(0, 60));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  sz;
        logic [31:0] a, d;
        int          kind, nm;

        rst = 1'b1;
        re_m = 0; we_m = 0; if_req = 0;
        rvalid_bit = 0; wvalid_bit = 0;
        raddr_m = 0; waddr_m = 0; wdata_m = 0; if_addr = 0;
        for (int i = 0; i < 4096; i++) ref_ram[i] = init_byte(12'(i));
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; ram_init = 1'b0;
        @(negedge clk);
        chk("reset_rdata_m", rdata_m, 32'd0);
        chk("reset_if_data", if_data, 32'd0);
        chk("reset_if_done", {31'b0, if_done}, 32'd0);
        chk("reset_mem_wr", {31'b0, mem_wr}, 32'd0);
        chk("reset_mem_a", mem_a, 32'd0);
        chk("reset_mem_dout", {24'b0, mem_dout}, 32'd0);
        chk("reset_stall", {31'b0, stall_req}, 32'd0);

        preset(32'h100, 8'h11); preset(32'h101, 8'h22);
        preset(32'h102, 8'h33); preset(32'h103, 8'h44);
        preset(32'h201, 8'h80);
        data_op(0, 2'b11, 32'h100, 0, 0, 0);
        chk("word_read_value", rdata_m, 32'h4433_2211);
        data_op(0, 2'b01, 32'h201, 0, 0, 0);
        chk("byte_read_value", rdata_m, 32'h0000_0080);

        data_op(1, 2'b10, 32'h300, 32'hDEAD_BEEF, 0, 0);
        @(posedge clk);
        #1;
        chk("half_write_b0", {24'b0, dev_ram[12'h300]}, 32'h0000_00EF);
        chk("half_write_b1", {24'b0, dev_ram[12'h301]}, 32'h0000_00BE);
        chk("half_write_b2_untouched", {24'b0, dev_ram[12'h302]}, {24'b0, init_byte(12'h302)});

        data_op(0, 2'b11, 32'h10, 0, 1, 32'h0);
        data_op(0, 2'b11, 32'hFFFF_FFFE, 0, 0, 0);
        fetch_op(32'h20);

        @(posedge clk);
        #1;
        re_m = 1'b1; rvalid_bit = 2'b00; raddr_m = 32'h100;
        we_m = 1'b1; wvalid_bit = 2'b00; waddr_m = 32'h104;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("size0_stall", {31'b0, stall_req}, 32'd0);
            chk("size0_mem_wr", {31'b0, mem_wr}, 32'd0);
            chk("size0_mem_a", mem_a, 32'd0);
        end
        @(posedge clk);
        #1 re_m = 1'b0; we_m = 1'b0;

        // Reset lands while the third byte of a word write is on the bus.
        @(posedge clk);
        #1;
        we_m = 1'b1; wvalid_bit = 2'b11; waddr_m = 32'h180; wdata_m = 32'hA1B2_C3D4;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_third_byte_addr", mem_a, 32'h182);
        chk("rst_forces_stall_low", {31'b0, stall_req}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0; we_m = 1'b0; wvalid_bit = 2'b00;
        chk("rst_mem_wr", {31'b0, mem_wr}, 32'd0);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_rdata_m", rdata_m, 32'd0);
        chk("rst_if_data", if_data, 32'd0);
        last_rd = '0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_byte0_written", {24'b0, dev_ram[12'h180]}, 32'h0000_00D4);
        chk("rst_byte1_written", {24'b0, dev_ram[12'h181]}, 32'h0000_00C3);
        chk("rst_no_fourth_byte", {24'b0, dev_ram[12'h183]}, {24'b0, init_byte(12'h183)});
        ref_ram[12'h180] = 8'hD4; ref_ram[12'h181] = 8'hC3; ref_ram[12'h182] = 8'hB2;

        for (int it = 0; it < 60; it++) begin
            kind = $urandom_range(0, 3);
            sz   = 2'($urandom_range(1, 3));
            a    = rnd_addr();
            d    = $urandom;
            case (kind)
                0: data_op(0, sz, a, 0, 0, 0);
                1: data_op(1, sz, a, d, 0, 0);
                2: fetch_op(32'($urandom_range(0, 60)));
                default: data_op(1'($urandom_range(0, 1)), sz, a, d, 1, 32'($urandom_range(0, 60)));
            endcase
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("dq_drained", 32'(dq.size()), 32'd0);
        chk("fq_drained", 32'(fq.size()), 32'd0);
        nm = 0;
        for (int i = 0; i < 4096; i++) if (dev_ram[i] !== ref_ram[i]) nm++;
        chk("ram_image_mismatches", 32'(nm), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
